// File: rtl/mac_feeder.sv
// Sequencer that feeds the mac_acc neuron engine from the pixel/weight ROMs and
// presents one 8-bit result per node on a valid/ready port.
module mac_feeder #(
  parameter int unsigned DW             = 128,
  parameter int unsigned AW             = 6,
  parameter int unsigned WORDS_PER_NODE = 4,
  parameter int unsigned NUM_NODES      = 10,
  parameter logic [7:0]  BIAS           = 8'd11,
  parameter int unsigned MAC_LAT        = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  input  logic [DW-1:0] p_rdata,
  input  logic [DW-1:0] w_rdata,
  output logic          mac_rst,
  output logic [DW-1:0] mac_p,
  output logic [DW-1:0] mac_w,
  output logic [7:0]    mac_b,
  input  logic [7:0]    mac_out,
  output logic          node_valid,
  input  logic          node_ready,
  output logic [3:0]    node_idx,
  output logic [7:0]    node_data
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_FETCH = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_EMIT  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam int unsigned CMAX = (WORDS_PER_NODE > MAC_LAT) ? WORDS_PER_NODE : MAC_LAT;
  localparam int unsigned CW   = $clog2(CMAX) + 1;

  localparam logic [CW-1:0] K_LAST = CW'(WORDS_PER_NODE - 1);
  localparam logic [CW-1:0] D_LAST = CW'(MAC_LAT - 1);
  localparam logic [3:0]    N_LAST = 4'(NUM_NODES - 1);

  logic [2:0]    state;
  logic [3:0]    node;
  logic [CW-1:0] cnt;
  logic [AW-1:0] base;
  logic          fetch_rd;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      node      <= '0;
      cnt       <= '0;
      node_data <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            node  <= '0;
            cnt   <= '0;
            state <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          cnt   <= '0;
          state <= S_FETCH;
        end
        S_FETCH: begin
          if (cnt == K_LAST) begin
            cnt   <= '0;
            state <= S_DRAIN;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_DRAIN: begin
          // mac_out is settled on the final drain cycle
          if (cnt == D_LAST) begin
            node_data <= mac_out;
            cnt       <= '0;
            state     <= S_EMIT;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_EMIT: begin
          if (node_ready) begin
            if (node == N_LAST) begin
              state <= S_DONE;
            end else begin
              node  <= node + 4'd1;
              state <= S_CLEAR;
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    base     = AW'(node * WORDS_PER_NODE);
    fetch_rd = (state == S_FETCH) && (cnt != K_LAST);

    busy       = (state != S_IDLE);
    done       = (state == S_DONE);
    node_valid = (state == S_EMIT);
    node_idx   = node;
    mac_b      = BIAS;
    mac_rst    = (state == S_IDLE) || (state == S_CLEAR) || (state == S_DONE);
    rd_en      = (state == S_CLEAR) || fetch_rd;

    // Address runs one word ahead of the data being presented (1-cycle ROM).
    rd_addr = '0;
    if (state == S_CLEAR) begin
      rd_addr = base;
    end else if (fetch_rd) begin
      rd_addr = base + AW'(cnt) + AW'(1);
    end

    mac_p = '0;
    mac_w = '0;
    if (state == S_FETCH) begin
      mac_p = p_rdata;
      mac_w = w_rdata;
    end
  end

endmodule

// File: tb/tb_mac_feeder.sv
// Self-checking bench for mac_feeder: sync ROMs, a behavioural mac_acc stand-in,
// and an arithmetic reference for per-node results and cycle timing.
module tb_mac_feeder;

  localparam int unsigned DW = 128;
  localparam int unsigned AW = 6;
  localparam int unsigned W  = 4;
  localparam int unsigned N  = 10;
  localparam int unsigned ML = 2;
  localparam logic [7:0]  BIAS = 8'd11;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          node_ready = 1'b1;
  logic          busy, done, rd_en, mac_rst, node_valid;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] p_rdata, w_rdata, mac_p, mac_w;
  logic [7:0]    mac_b, mac_out, node_data;
  logic [3:0]    node_idx;

  logic [DW-1:0] prom [0:63];
  logic [DW-1:0] wrom [0:63];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int s_cyc    = 0;
  bit sc1      = 1'b0;
  int done_cnt = 0;
  int done_cyc = 0;
  int vtotal   = 0;
  int vcnt [0:15];
  int got_idx[$];
  int got_data[$];
  int got_cyc[$];
  int unsigned mac_acc_q = 0;

  mac_feeder #(
    .DW(DW), .AW(AW), .WORDS_PER_NODE(W), .NUM_NODES(N), .BIAS(BIAS), .MAC_LAT(ML)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .rd_en(rd_en), .rd_addr(rd_addr), .p_rdata(p_rdata), .w_rdata(w_rdata),
    .mac_rst(mac_rst), .mac_p(mac_p), .mac_w(mac_w), .mac_b(mac_b),
    .mac_out(mac_out), .node_valid(node_valid), .node_ready(node_ready),
    .node_idx(node_idx), .node_data(node_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (rd_en) begin
      p_rdata <= prom[rd_addr];
      w_rdata <= wrom[rd_addr];
    end
  end

  function automatic int unsigned dot(input logic [DW-1:0] a, input logic [DW-1:0] b);
    int unsigned s = 0;
    for (int i = 0; i < 16; i++) s += a[8*i +: 8] * b[8*i +: 8];
    return s;
  endfunction

  function automatic logic [7:0] act(input int unsigned acc, input logic [7:0] b);
    int unsigned v = (acc >> 14) + b;
    return (v > 255) ? 8'hff : v[7:0];
  endfunction

  // mac_acc stand-in: accumulate register, then registered activation (2-cycle latency)
  always @(posedge clk) begin
    if (mac_rst) mac_acc_q <= 0;
    else         mac_acc_q <= mac_acc_q + dot(mac_p, mac_w);
    mac_out <= act(mac_acc_q, mac_b);
  end

  function automatic logic [7:0] ref_out(input int n);
    int unsigned s = 0;
    for (int k = 0; k < int'(W); k++) s += dot(prom[n*W+k], wrom[n*W+k]);
    return act(s, BIAS);
  endfunction

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (node_valid) begin
        vcnt[node_idx]++;
        vtotal++;
        check("emit_mac_zero", {mac_p, mac_w} == '0, 1'b1);
        check("emit_mac_rst", mac_rst, 1'b0);
      end
      if (node_valid && node_ready) begin
        got_idx.push_back(int'(node_idx));
        got_data.push_back(int'(node_data));
        got_cyc.push_back(cyc);
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (rd_en) check("addr_bound", rd_addr <= AW'(N*W-1), 1'b1);
      if (sc1) begin
        int off, n, ph;
        off = cyc - s_cyc;
        n = off / 8;
        ph = off % 8;
        if (off >= 0 && off < 80) begin
          check("tr_rd_en", rd_en, (ph < 4));
          if (ph < 4) check("tr_rd_addr", rd_addr, 4*n + ph);
          check("tr_mac_rst", mac_rst, (ph == 0));
          check("tr_mac_p", mac_p, (ph >= 1 && ph <= 4) ? prom[4*n+ph-1] : '0);
          check("tr_mac_w", mac_w, (ph >= 1 && ph <= 4) ? wrom[4*n+ph-1] : '0);
          check("tr_valid", node_valid, (ph == 7));
          check("tr_busy", busy, 1'b1);
        end else if (off == 80) begin
          check("tr_done", done, 1'b1);
          check("tr_busy_done", busy, 1'b1);
        end else if (off == 81) begin
          check("tr_busy_idle", busy, 1'b0);
          check("tr_done_low", done, 1'b0);
        end
      end
    end
  end

  task automatic clear_log();
    got_idx.delete();
    got_data.delete();
    got_cyc.delete();
    done_cnt = 0;
    vtotal = 0;
    for (int i = 0; i < 16; i++) vcnt[i] = 0;
  endtask

  task automatic fill_random();
    for (int a = 0; a < 64; a++)
      for (int l = 0; l < 4; l++) begin
        prom[a][32*l +: 32] = $urandom;
        wrom[a][32*l +: 32] = $urandom;
      end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_rd_en"}, rd_en, 1'b0);
    check({tag, "_valid"}, node_valid, 1'b0);
    check({tag, "_mac_rst"}, mac_rst, 1'b1);
    check({tag, "_rd_addr"}, rd_addr, '0);
    check({tag, "_idx"}, node_idx, '0);
    check({tag, "_data"}, node_data, '0);
    check({tag, "_mac_pw"}, {mac_p, mac_w} == '0, 1'b1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    s_cyc = cyc;
  endtask

  task automatic wait_done(input int max);
    int t = 0;
    while (done_cnt == 0 && t < max) begin
      @(posedge clk);
      t++;
    end
    check("done_seen", done_cnt != 0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check_image(input string tag);
    check({tag, "_n_results"}, got_idx.size(), N);
    check({tag, "_n_done"}, done_cnt, 1);
    for (int i = 0; i < got_idx.size() && i < int'(N); i++) begin
      check({tag, "_idx"}, got_idx[i], i);
      check({tag, "_data"}, got_data[i], ref_out(i));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int a = 0; a < 64; a++) begin
      logic [7:0] b;
      b = 8'(a);
      prom[a] = {16{b}};
      wrom[a] = {16{b}};
    end
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    check("rst_mac_b", mac_b, BIAS);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Image 1: address pattern ROMs, free-running ready, full cycle trace
    clear_log();
    pulse_start();
    sc1 = 1'b1;
    wait_done(200);
    sc1 = 1'b0;
    check_image("img1");
    for (int i = 0; i < got_cyc.size() && i < int'(N); i++)
      check("img1_valid_cyc", got_cyc[i], s_cyc + 7 + 8*i);
    check("img1_done_cyc", done_cyc, s_cyc + 80);

    // Image 2: random ROMs, backpressure at node 2
    fill_random();
    clear_log();
    pulse_start();
    begin
      int t = 0;
      logic [7:0] d;
      while (!(node_valid && node_idx == 4'd2) && t < 100) begin
        @(posedge clk);
        #1;
        t++;
      end
      check("stall_reach", node_valid && node_idx == 4'd2, 1'b1);
      node_ready = 1'b0;
      d = node_data;
      for (int i = 0; i < 5; i++) begin
        @(posedge clk);
        #1;
        check("stall_valid", node_valid, 1'b1);
        check("stall_idx", node_idx, 4'd2);
        check("stall_data", node_data, d);
        check("stall_rd_en", rd_en, 1'b0);
      end
      node_ready = 1'b1;
      @(posedge clk);
      #1;
      check("n3_clear_rst", mac_rst, 1'b1);
      check("n3_clear_en", rd_en, 1'b1);
      check("n3_clear_addr", rd_addr, 6'd12);
    end
    wait_done(200);
    check("stall_vcnt", vcnt[2], 6);
    check_image("img2");

    // Image 3: abort with reset during FETCH of node 5
    fill_random();
    clear_log();
    pulse_start();
    repeat (42) @(posedge clk);
    #1;
    check("abort_addr", rd_addr, 6'd22);
    rst = 1'b0;
    #1;
    check_reset_outputs("abort");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    clear_log();
    repeat (30) @(posedge clk);
    #1;
    check("abort_no_valid", vtotal, 0);
    check("abort_no_done", done_cnt, 0);
    check("abort_idle", busy, 1'b0);

    // Image 4: start pulses while busy and in the DONE cycle are ignored
    fill_random();
    clear_log();
    pulse_start();
    repeat (34) @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    begin
      int t = 0;
      while (!done && t < 200) begin
        @(posedge clk);
        #1;
        t++;
      end
      check("img4_done_seen", done, 1'b1);
    end
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    check("img4_idle", busy, 1'b0);
    check_image("img4");
    if (got_cyc.size() == int'(N)) check("img4_last_cyc", got_cyc[N-1], s_cyc + 79);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
